// File: rtl/alarm_pkg.sv
// alarm_pkg: state encoding, state width and default timing constants
// shared by the alarm controller, its interface and its testbench.
package alarm_pkg;

   localparam int STATE_W        = 3;
   localparam int RING_SEC_DEF   = 60;
   localparam int SNOOZE_SEC_DEF = 300;
   localparam int IDLE_SEC_DEF   = 30;

   // snoozes allowed per alarm event
   localparam logic [1:0] MAX_SNZ = 2'd3;

   typedef enum logic [STATE_W-1:0] {
      S_RUN   = 3'd0,
      S_T_HRS = 3'd1,
      S_T_MIN = 3'd2,
      S_A_HRS = 3'd3,
      S_A_MIN = 3'd4,
      S_RING  = 3'd5,
      S_SNZ   = 3'd6
   } state_t;

   function automatic int max3(int a, int b, int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // mode-button walk through the set screens
   function automatic state_t mode_next(state_t s);
      state_t n;
      n = S_RUN;
      unique case (s)
         S_RUN:   n = S_T_HRS;
         S_T_HRS: n = S_T_MIN;
         S_T_MIN: n = S_A_HRS;
         S_A_HRS: n = S_A_MIN;
         default: n = S_RUN;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/alarm_if.sv
// alarm_if: button/level inputs and control outputs of alarm_ctrl.
// i_* flow into the controller, o_* flow out; slave = controller side.
interface alarm_if;
   import alarm_pkg::*;

   logic               i_tick_1hz;
   logic               i_mode_btn;
   logic               i_inc_btn;
   logic               i_snooze_btn;
   logic               i_alarm_en;
   logic               i_alarm_match;

   logic               o_run;
   logic               o_time_set;
   logic               o_alarm_set;
   logic               o_sethrs1min0;
   logic               o_inc_pulse;
   logic               o_alarmreset;
   logic               o_buzzer;
   logic [STATE_W-1:0] o_state;

   modport master (
      output i_tick_1hz, i_mode_btn, i_inc_btn,
      output i_snooze_btn, i_alarm_en, i_alarm_match,
      input  o_run, o_time_set, o_alarm_set,
      input  o_sethrs1min0, o_inc_pulse,
      input  o_alarmreset, o_buzzer, o_state
   );

   modport slave (
      input  i_tick_1hz, i_mode_btn, i_inc_btn,
      input  i_snooze_btn, i_alarm_en, i_alarm_match,
      output o_run, o_time_set, o_alarm_set,
      output o_sethrs1min0, o_inc_pulse,
      output o_alarmreset, o_buzzer, o_state
   );

endinterface

// File: rtl/alarm_ctrl_btn_sync.sv
// btn_sync: 2-flop synchronizer plus rising-edge detect for one raw button.
// Ports: clk, rst_n (async low), i_btn raw level, o_rise one-clk edge pulse.
module btn_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_rise
);

   logic [1:0] r_sync;
   logic       r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= 2'b00;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_btn};
         r_prev <= r_sync[1];
      end
   end

   assign o_rise = r_sync[1] & ~r_prev;

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: clock/alarm mode FSM with ring timeout, idle exit and
// optional snooze (enabled by defining ALARM_SNOOZE_EN).
// Ports: clk, reset (async active-low), io_bus (alarm_if.slave):
//   inputs tick_1hz, mode/inc/snooze buttons, alarm_en, alarm_match;
//   outputs run, time_set, alarm_set, sethrs1min0, inc_pulse,
//   alarmreset, buzzer, state.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int RING_SEC   = RING_SEC_DEF,
   parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
   parameter int IDLE_SEC   = IDLE_SEC_DEF
) (
   input  logic   clk,
   input  logic   reset,
   alarm_if.slave io_bus
);

   localparam int CNT_W =
      $clog2(max3(RING_SEC, SNOOZE_SEC, IDLE_SEC) + 1);

   // count value on the tick that completes the interval
   localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SEC - 1);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_SEC - 1);
`ifdef ALARM_SNOOZE_EN
   localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(SNOOZE_SEC - 1);
`endif

   state_t           r_state;
   state_t           w_nxt;
   logic [CNT_W-1:0] r_sec;
   logic [CNT_W-1:0] r_idle;
   logic             r_inc;
   logic             r_arst;
   logic             w_inc_nxt;
   logic             w_arst_nxt;

   logic w_tick;
   logic w_en;
   logic w_match;
   logic w_mode_rise;
   logic w_inc_rise;
   logic w_snz_rise;
   logic w_any_btn;
   logic w_is_set;
   logic w_timed;
   logic w_ring_hit;
   logic w_ring_done;
   logic w_idle_done;

`ifdef ALARM_SNOOZE_EN
   logic [1:0] r_snz_n;
   logic       w_snz_take;
   logic       w_snz_done;
`endif

   logic w_run;
   logic w_time_set;
   logic w_alarm_set;
   logic w_sethrs;
   logic w_buzzer;

   assign w_tick  = io_bus.i_tick_1hz;
   assign w_en    = io_bus.i_alarm_en;
   assign w_match = io_bus.i_alarm_match;

   btn_sync u_mode_sync (
      .clk    (clk),
      .rst_n  (reset),
      .i_btn  (io_bus.i_mode_btn),
      .o_rise (w_mode_rise)
   );

   btn_sync u_inc_sync (
      .clk    (clk),
      .rst_n  (reset),
      .i_btn  (io_bus.i_inc_btn),
      .o_rise (w_inc_rise)
   );

   btn_sync u_snz_sync (
      .clk    (clk),
      .rst_n  (reset),
      .i_btn  (io_bus.i_snooze_btn),
      .o_rise (w_snz_rise)
   );

   // snooze presses also count as activity for the idle timer
   assign w_any_btn = w_mode_rise | w_inc_rise | w_snz_rise;

   assign w_is_set = (r_state == S_T_HRS) | (r_state == S_T_MIN) |
                     (r_state == S_A_HRS) | (r_state == S_A_MIN);
   assign w_timed  = (r_state == S_RING) | (r_state == S_SNZ);

   assign w_ring_hit  = w_tick & w_match & w_en;
   assign w_ring_done = w_tick & (r_sec == RING_LAST);
   assign w_idle_done = w_tick & ~w_any_btn &
                        (r_idle == IDLE_LAST);
`ifdef ALARM_SNOOZE_EN
   assign w_snz_done  = w_tick & (r_sec == SNZ_LAST);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_nxt;
      end
   end

   always_comb begin
      w_nxt      = r_state;
      w_inc_nxt  = 1'b0;
      w_arst_nxt = 1'b0;
`ifdef ALARM_SNOOZE_EN
      w_snz_take = 1'b0;
`endif
      unique case (r_state)
         S_RUN: begin
            if (w_ring_hit) begin
               w_nxt = S_RING;
            end else if (w_mode_rise) begin
               w_nxt = S_T_HRS;
            end
         end
         S_T_HRS, S_T_MIN, S_A_HRS, S_A_MIN: begin
            if (w_mode_rise) begin
               w_nxt = mode_next(r_state);
            end else begin
               w_inc_nxt = w_inc_rise;
               if (w_idle_done) begin
                  w_nxt = S_RUN;
               end
            end
         end
         S_RING: begin
            if (w_mode_rise | ~w_en | w_ring_done) begin
               w_nxt      = S_RUN;
               w_arst_nxt = 1'b1;
            end
`ifdef ALARM_SNOOZE_EN
            else if (w_snz_rise && (r_snz_n < MAX_SNZ)) begin
               w_nxt      = S_SNZ;
               w_snz_take = 1'b1;
            end
`endif
         end
`ifdef ALARM_SNOOZE_EN
         S_SNZ: begin
            if (w_mode_rise | ~w_en) begin
               w_nxt      = S_RUN;
               w_arst_nxt = 1'b1;
            end else if (w_snz_done) begin
               w_nxt = S_RING;
            end
         end
`endif
         default: begin
            w_nxt = S_RUN;
         end
      endcase
   end

   // counters restart on every state change and saturate
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sec  <= '0;
         r_idle <= '0;
         r_inc  <= 1'b0;
         r_arst <= 1'b0;
      end else begin
         r_inc  <= w_inc_nxt;
         r_arst <= w_arst_nxt;
         if (w_nxt != r_state) begin
            r_sec <= '0;
         end else if (w_tick && w_timed && (r_sec != '1)) begin
            r_sec <= r_sec + 1'b1;
         end
         if ((w_nxt != r_state) || w_any_btn) begin
            r_idle <= '0;
         end else if (w_tick && w_is_set && (r_idle != '1)) begin
            r_idle <= r_idle + 1'b1;
         end
      end
   end

`ifdef ALARM_SNOOZE_EN
   // snooze budget lasts one alarm event, refilled on return to RUN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_snz_n <= 2'd0;
      end else if (w_nxt == S_RUN) begin
         r_snz_n <= 2'd0;
      end else if (w_snz_take) begin
         r_snz_n <= r_snz_n + 2'd1;
      end
   end
`endif

   always_comb begin
      w_run       = 1'b1;
      w_time_set  = 1'b0;
      w_alarm_set = 1'b0;
      w_sethrs    = 1'b0;
      w_buzzer    = 1'b0;
      unique case (r_state)
         S_T_HRS: begin
            w_run      = 1'b0;
            w_time_set = 1'b1;
            w_sethrs   = 1'b1;
         end
         S_T_MIN: begin
            w_run      = 1'b0;
            w_time_set = 1'b1;
         end
         S_A_HRS: begin
            w_alarm_set = 1'b1;
            w_sethrs    = 1'b1;
         end
         S_A_MIN: begin
            w_alarm_set = 1'b1;
         end
         S_RING: begin
            w_buzzer = 1'b1;
         end
         default: begin
            w_run = 1'b1;
         end
      endcase
   end

   assign io_bus.o_run         = w_run;
   assign io_bus.o_time_set    = w_time_set;
   assign io_bus.o_alarm_set   = w_alarm_set;
   assign io_bus.o_sethrs1min0 = w_sethrs;
   assign io_bus.o_buzzer      = w_buzzer;
   assign io_bus.o_inc_pulse   = r_inc;
   assign io_bus.o_alarmreset  = r_arst;
   assign io_bus.o_state       = r_state;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed stimulus with a behavioural reference model
// and literal spot checks for alarm_ctrl (RING=4, SNOOZE=2, IDLE=30).
module tb_alarm_ctrl;
   import alarm_pkg::*;

   localparam int RING_SEC   = 4;
   localparam int SNOOZE_SEC = 2;
   localparam int IDLE_SEC   = 30;
`ifdef ALARM_SNOOZE_EN
   localparam bit SNZ_EN = 1'b1;
`else
   localparam bit SNZ_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   int   n_inc = 0;
   int   n_arst = 0;

   alarm_if u_if ();

   alarm_ctrl #(
      .RING_SEC   (RING_SEC),
      .SNOOZE_SEC (SNOOZE_SEC),
      .IDLE_SEC   (IDLE_SEC)
   ) u_dut (
      .clk    (clk),
      .reset  (rst_n),
      .io_bus (u_if)
   );

   always #5 clk = ~clk;

   // reference model state
   state_t   m_st = S_RUN;
   int       m_tin = 0;
   int       m_idle = 0;
   int       m_snz = 0;
   bit       m_inc = 1'b0;
   bit       m_arst = 1'b0;
   bit [2:0] hm = '0;
   bit [2:0] hi = '0;
   bit [2:0] hs = '0;
   state_t   seq [5] = '{S_RUN, S_T_HRS, S_T_MIN, S_A_HRS, S_A_MIN};

   function automatic state_t seq_next(state_t s);
      state_t n;
      n = S_RUN;
      for (int i = 0; i < 5; i++) begin
         if (seq[i] == s) n = seq[(i + 1) % 5];
      end
      return n;
   endfunction

   // {run, time_set, alarm_set, sethrs1min0, buzzer}
   function automatic logic [4:0] exp_outs(state_t s);
      logic [4:0] v;
      case (s)
         S_T_HRS: v = 5'b01010;
         S_T_MIN: v = 5'b01000;
         S_A_HRS: v = 5'b10110;
         S_A_MIN: v = 5'b10100;
         S_RING:  v = 5'b10001;
         default: v = 5'b10000;
      endcase
      return v;
   endfunction

   function automatic logic [9:0] act_vec();
      return {u_if.o_state, u_if.o_run, u_if.o_time_set,
              u_if.o_alarm_set, u_if.o_sethrs1min0,
              u_if.o_buzzer, u_if.o_inc_pulse,
              u_if.o_alarmreset};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Button edges reach the FSM two samples after the raw level rises.
   task automatic model_step();
      bit     me, ie, se, anyb, tk, en, mt;
      state_t nst;
      if (!rst_n) begin
         m_st = S_RUN; m_tin = 0; m_idle = 0; m_snz = 0;
         m_inc = 1'b0; m_arst = 1'b0;
         hm = '0; hi = '0; hs = '0;
      end else begin
         me = hm[1] & ~hm[2];
         ie = hi[1] & ~hi[2];
         se = hs[1] & ~hs[2];
         hm = {hm[1:0], u_if.i_mode_btn};
         hi = {hi[1:0], u_if.i_inc_btn};
         hs = {hs[1:0], u_if.i_snooze_btn};
         anyb = me | ie | se;
         tk = u_if.i_tick_1hz;
         en = u_if.i_alarm_en;
         mt = u_if.i_alarm_match;
         nst = m_st;
         m_inc = 1'b0;
         m_arst = 1'b0;
         case (m_st)
            S_RUN: begin
               if (tk && mt && en) nst = S_RING;
               else if (me) nst = S_T_HRS;
            end
            S_RING: begin
               m_tin = m_tin + int'(tk);
               if (me || !en || m_tin >= RING_SEC) begin
                  nst = S_RUN; m_arst = 1'b1;
               end else if (SNZ_EN && se && m_snz < 3) begin
                  nst = S_SNZ; m_snz++;
               end
            end
            S_SNZ: begin
               m_tin = m_tin + int'(tk);
               if (me || !en) begin
                  nst = S_RUN; m_arst = 1'b1;
               end else if (m_tin >= SNOOZE_SEC) begin
                  nst = S_RING;
               end
            end
            default: begin
               if (me) begin
                  nst = seq_next(m_st);
               end else begin
                  m_inc = ie;
                  m_idle = anyb ? 0 : m_idle + int'(tk);
                  if (m_idle >= IDLE_SEC) nst = S_RUN;
               end
            end
         endcase
         if (nst != m_st) begin
            m_tin = 0;
            m_idle = 0;
         end
         if (nst == S_RUN) m_snz = 0;
         m_st = nst;
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("cycle", 32'(act_vec()),
             32'({m_st, exp_outs(m_st), m_inc, m_arst}));
         if (u_if.o_inc_pulse) n_inc++;
         if (u_if.o_alarmreset) n_arst++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int b);
      case (b)
         0: u_if.i_mode_btn = 1'b1;
         1: u_if.i_inc_btn = 1'b1;
         default: u_if.i_snooze_btn = 1'b1;
      endcase
      cyc(1);
      u_if.i_mode_btn = 1'b0;
      u_if.i_inc_btn = 1'b0;
      u_if.i_snooze_btn = 1'b0;
      cyc(4);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         u_if.i_tick_1hz = 1'b1;
         cyc(1);
         u_if.i_tick_1hz = 1'b0;
         cyc(1);
      end
   endtask

   task automatic ring();
      u_if.i_alarm_match = 1'b1;
      tick(1);
      u_if.i_alarm_match = 1'b0;
   endtask

   initial begin
      int     c0;
      state_t steps [5];
      steps = '{S_T_HRS, S_T_MIN, S_A_HRS, S_A_MIN, S_RUN};
      u_if.i_tick_1hz = 1'b0;
      u_if.i_mode_btn = 1'b0;
      u_if.i_inc_btn = 1'b0;
      u_if.i_snooze_btn = 1'b0;
      u_if.i_alarm_en = 1'b1;
      u_if.i_alarm_match = 1'b0;
      cyc(3);
      chk("reset_outs", 32'(act_vec()), 32'h040);
      rst_n = 1'b1;
      cyc(2);

      for (int i = 0; i < 5; i++) begin
         press(0);
         chk("mode_step", 32'(u_if.o_state), 32'(steps[i]));
      end

      press(0);
      c0 = n_inc;
      press(1); press(1); press(1);
      chk("inc_count", 32'(n_inc - c0), 32'd3);
      chk("thrs_flags", 32'({u_if.o_sethrs1min0, u_if.o_run}), 32'h2);
      u_if.i_mode_btn = 1'b1;
      u_if.i_inc_btn = 1'b1;
      cyc(1);
      u_if.i_mode_btn = 1'b0;
      u_if.i_inc_btn = 1'b0;
      cyc(4);
      chk("mode_wins", 32'(u_if.o_state), 32'(S_T_MIN));
      chk("inc_dropped", 32'(n_inc - c0), 32'd3);

      press(0); press(0);
      u_if.i_alarm_match = 1'b1;
      tick(29);
      chk("amin_no_ring", 32'(u_if.o_state), 32'(S_A_MIN));
      tick(1);
      u_if.i_alarm_match = 1'b0;
      chk("idle_exit", 32'(u_if.o_state), 32'(S_RUN));

      c0 = n_arst;
      ring();
      chk("ring_entry", 32'({u_if.o_state, u_if.o_buzzer}),
          32'({S_RING, 1'b1}));
      tick(3);
      chk("ring_hold", 32'(u_if.o_state), 32'(S_RING));
      tick(1);
      chk("ring_timeout", 32'(u_if.o_state), 32'(S_RUN));
      chk("arst_once", 32'(n_arst - c0), 32'd1);

      u_if.i_alarm_match = 1'b1;
      u_if.i_mode_btn = 1'b1;
      cyc(1);
      u_if.i_mode_btn = 1'b0;
      cyc(1);
      u_if.i_tick_1hz = 1'b1;
      cyc(1);
      u_if.i_tick_1hz = 1'b0;
      u_if.i_alarm_match = 1'b0;
      cyc(1);
      chk("ring_prio", 32'(u_if.o_state), 32'(S_RING));
      c0 = n_arst;
      press(0);
      chk("ring_mode_exit", 32'(u_if.o_state), 32'(S_RUN));
      chk("arst_mode", 32'(n_arst - c0), 32'd1);

      ring();
`ifdef ALARM_SNOOZE_EN
      for (int i = 0; i < 3; i++) begin
         press(2);
         chk("snz_enter", 32'({u_if.o_state, u_if.o_buzzer}),
             32'({S_SNZ, 1'b0}));
         tick(1);
         chk("snz_hold", 32'(u_if.o_state), 32'(S_SNZ));
         tick(1);
         chk("snz_rering", 32'(u_if.o_state), 32'(S_RING));
      end
      press(2);
      chk("snz_4th", 32'(u_if.o_state), 32'(S_RING));
`else
      press(2);
      chk("snz_ignored", 32'(u_if.o_state), 32'(S_RING));
`endif
      u_if.i_alarm_en = 1'b0;
      cyc(2);
      chk("en_drop_exit", 32'(u_if.o_state), 32'(S_RUN));
      u_if.i_alarm_en = 1'b1;

      press(0);
      tick(20);
      press(1);
      tick(20);
      chk("idle_cleared", 32'(u_if.o_state), 32'(S_T_HRS));
      tick(10);
      chk("idle_30", 32'(u_if.o_state), 32'(S_RUN));

      u_if.i_alarm_en = 1'b0;
      u_if.i_alarm_match = 1'b1;
      tick(1);
      chk("disarmed", 32'(u_if.o_state), 32'(S_RUN));
      u_if.i_alarm_match = 1'b0;
      u_if.i_alarm_en = 1'b1;

      ring();
      chk("ring_again", 32'(u_if.o_state), 32'(S_RING));
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("async_reset", 32'(act_vec()), 32'h040);
      u_if.i_mode_btn = 1'b1;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      chk("held_btn_first", 32'(u_if.o_state), 32'(S_RUN));
      u_if.i_mode_btn = 1'b0;
      cyc(5);
      press(0); press(0); press(0); press(0);
      chk("final_run", 32'(u_if.o_state), 32'(S_RUN));
      cyc(3);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
